// File: rtl/ctrl_pkg.sv
// Shared opcode, ALU-code and control-bundle definitions for the ID-stage decoder.
package ctrl_pkg;

  localparam int OPCODE_W   = 6;
  localparam int ALU_CODE_W = 4;
  localparam int ALUSRC_W   = 2;
  localparam int WB_SEL_W   = 2;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPCODE_W-1:0] OP_SLTIU = 6'b001011;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPCODE_W-1:0] OP_LUI   = 6'b001111;
  localparam logic [OPCODE_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OPCODE_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OPCODE_W-1:0] OP_BLEZ  = 6'b000110;
  localparam logic [OPCODE_W-1:0] OP_BGTZ  = 6'b000111;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;
  localparam logic [OPCODE_W-1:0] OP_JAL   = 6'b000011;

  localparam logic [ALU_CODE_W-1:0] ALU_RTYPE = 4'd0;
  localparam logic [ALU_CODE_W-1:0] ALU_ADDI  = 4'd1;
  localparam logic [ALU_CODE_W-1:0] ALU_SLTIU = 4'd2;
  localparam logic [ALU_CODE_W-1:0] ALU_BEQ   = 4'd3;
  localparam logic [ALU_CODE_W-1:0] ALU_LUI   = 4'd4;
  localparam logic [ALU_CODE_W-1:0] ALU_ORI   = 4'd5;
  localparam logic [ALU_CODE_W-1:0] ALU_BNE   = 4'd6;
  localparam logic [ALU_CODE_W-1:0] ALU_LW    = 4'd7;
  localparam logic [ALU_CODE_W-1:0] ALU_SW    = 4'd8;
  localparam logic [ALU_CODE_W-1:0] ALU_BLEZ  = 4'd9;
  localparam logic [ALU_CODE_W-1:0] ALU_BGTZ  = 4'd10;
  localparam logic [ALU_CODE_W-1:0] ALU_J     = 4'd11;
  localparam logic [ALU_CODE_W-1:0] ALU_JAL   = 4'd12;

  localparam logic [ALUSRC_W-1:0] ALUSRC_REG  = 2'd0;
  localparam logic [ALUSRC_W-1:0] ALUSRC_IMM  = 2'd1;
  localparam logic [ALUSRC_W-1:0] ALUSRC_ZERO = 2'd2;

  localparam logic [WB_SEL_W-1:0] WB_ALU = 2'd0;
  localparam logic [WB_SEL_W-1:0] WB_MEM = 2'd1;
  localparam logic [WB_SEL_W-1:0] WB_PC4 = 2'd2;

  typedef enum logic [1:0] {DST_NONE, DST_RD, DST_RT, DST_LINK} dst_sel_e;

  typedef struct packed {
    logic [ALU_CODE_W-1:0] alu_code;
    logic [ALUSRC_W-1:0]   alusrc;
    logic                  branch;
    logic                  branch_eq;
    logic                  memread;
    logic                  memwrite;
    logic                  regwrite;
    logic [WB_SEL_W-1:0]   wb_sel;
  } ctrl_t;

endpackage

// File: rtl/ctrl_decode_stage_if.sv
// ID-side inputs and ID/EX control outputs of the decode stage, bundled with directional views.
interface ctrl_decode_stage_if #(
  parameter int INSTR_W = 32,
  parameter int ALUOP_W = 4,
  parameter int RADDR_W = 5
) ();

  logic [INSTR_W-1:0] instr_i;
  logic               instr_valid_i;
  logic               flush_i;
  logic               hold_i;
  logic               stall_o;
  logic               ex_valid_o;
  logic [ALUOP_W-1:0] ex_alu_op_o;
  logic [1:0]         ex_alusrc_o;
  logic               ex_branch_o;
  logic               ex_branch_eq_o;
  logic               ex_memread_o;
  logic               ex_memwrite_o;
  logic               ex_regwrite_o;
  logic [1:0]         ex_wb_sel_o;
  logic [RADDR_W-1:0] ex_rs_o;
  logic [RADDR_W-1:0] ex_rt_o;
  logic [RADDR_W-1:0] ex_dst_o;
  logic               ex_illegal_o;

  // instr_i is consumed on an edge where instr_valid_i=1 and stall_o=0 and flush_i=0;
  // while stall_o=1 the producer must hold instr_i steady; ex_valid_o marks a real op in EX.
  modport slave (
    input  instr_i, instr_valid_i, flush_i, hold_i,
    output stall_o, ex_valid_o, ex_alu_op_o, ex_alusrc_o, ex_branch_o, ex_branch_eq_o,
           ex_memread_o, ex_memwrite_o, ex_regwrite_o, ex_wb_sel_o, ex_rs_o, ex_rt_o,
           ex_dst_o, ex_illegal_o
  );

  modport master (
    output instr_i, instr_valid_i, flush_i, hold_i,
    input  stall_o, ex_valid_o, ex_alu_op_o, ex_alusrc_o, ex_branch_o, ex_branch_eq_o,
           ex_memread_o, ex_memwrite_o, ex_regwrite_o, ex_wb_sel_o, ex_rs_o, ex_rt_o,
           ex_dst_o, ex_illegal_o
  );

endinterface

// File: rtl/ctrl_decode_comb.sv
// Pure opcode decoder: control bundle, resolved destination, illegal flag and source usage.
module ctrl_decode_comb
  import ctrl_pkg::*;
#(
  parameter int INSTR_W = 32,
  parameter int RADDR_W = 5,
  parameter int EN_BZ   = 1
) (
  input  logic [INSTR_W-1:0] instr,
  input  logic               instr_valid,
  output ctrl_t              ctrl,
  output logic [RADDR_W-1:0] rs,
  output logic [RADDR_W-1:0] rt,
  output logic [RADDR_W-1:0] dst,
  output logic               illegal,
  output logic               uses_rs,
  output logic               uses_rt
);

  localparam int   LOW_W = INSTR_W - 16 - RADDR_W;
  localparam logic BZ_ON = (EN_BZ != 0);

  logic [OPCODE_W-1:0] opcode;
  logic [RADDR_W-1:0]  rd;
  dst_sel_e            dst_sel;
  logic                unused_low;

  assign opcode     = instr[INSTR_W-1 -: OPCODE_W];
  assign rs         = instr[INSTR_W-7 -: RADDR_W];
  assign rt         = instr[INSTR_W-12 -: RADDR_W];
  assign rd         = instr[INSTR_W-17 -: RADDR_W];
  assign unused_low = ^instr[LOW_W-1:0];

  always_comb begin
    ctrl    = '0;
    dst_sel = DST_NONE;
    illegal = 1'b0;
    case (opcode)
      OP_RTYPE: begin ctrl.alu_code = ALU_RTYPE; ctrl.regwrite = 1'b1; dst_sel = DST_RD; end
      OP_ADDI:  begin ctrl.alu_code = ALU_ADDI;  ctrl.alusrc = ALUSRC_IMM; ctrl.regwrite = 1'b1; dst_sel = DST_RT; end
      OP_SLTIU: begin ctrl.alu_code = ALU_SLTIU; ctrl.alusrc = ALUSRC_IMM; ctrl.regwrite = 1'b1; dst_sel = DST_RT; end
      OP_BEQ:   begin ctrl.alu_code = ALU_BEQ;   ctrl.branch = 1'b1; ctrl.branch_eq = 1'b1; end
      OP_LUI:   begin ctrl.alu_code = ALU_LUI;   ctrl.alusrc = ALUSRC_IMM; ctrl.regwrite = 1'b1; dst_sel = DST_RT; end
      OP_ORI:   begin ctrl.alu_code = ALU_ORI;   ctrl.alusrc = ALUSRC_IMM; ctrl.regwrite = 1'b1; dst_sel = DST_RT; end
      OP_BNE:   begin ctrl.alu_code = ALU_BNE;   ctrl.branch = 1'b1; end
      OP_LW: begin
        ctrl.alu_code = ALU_LW;
        ctrl.alusrc   = ALUSRC_IMM;
        ctrl.memread  = 1'b1;
        ctrl.regwrite = 1'b1;
        ctrl.wb_sel   = WB_MEM;
        dst_sel       = DST_RT;
      end
      OP_SW:    begin ctrl.alu_code = ALU_SW;    ctrl.alusrc = ALUSRC_IMM; ctrl.memwrite = 1'b1; end
      OP_BLEZ: begin
        if (BZ_ON) begin ctrl.alu_code = ALU_BLEZ; ctrl.alusrc = ALUSRC_ZERO; end
        else illegal = 1'b1;
      end
      OP_BGTZ: begin
        if (BZ_ON) begin ctrl.alu_code = ALU_BGTZ; ctrl.alusrc = ALUSRC_ZERO; end
        else illegal = 1'b1;
      end
      OP_J:     ctrl.alu_code = ALU_J;
      OP_JAL: begin
        ctrl.alu_code = ALU_JAL;
        ctrl.regwrite = 1'b1;
        ctrl.wb_sel   = WB_PC4;
        dst_sel       = DST_LINK;
      end
      default:  illegal = 1'b1;
    endcase
  end

  always_comb begin
    dst = '0;
    case (dst_sel)
      DST_RD:   dst = rd;
      DST_RT:   dst = rt;
      DST_LINK: dst = '1;
      default:  dst = '0;
    endcase
  end

  // Illegal encodings still count as rs readers so a hazard can never be missed on them.
  assign uses_rs = instr_valid & !(opcode inside {OP_J, OP_JAL, OP_LUI});
  assign uses_rt = instr_valid & (opcode inside {OP_RTYPE, OP_BEQ, OP_BNE, OP_SW});

endmodule

// File: rtl/ctrl_decode_stage.sv
// Pipelined ID stage: decode into an ID/EX control register with load-use stall and bubble count.
module ctrl_decode_stage
  import ctrl_pkg::*;
#(
  parameter int INSTR_W = 32,
  parameter int ALUOP_W = 4,
  parameter int RADDR_W = 5,
  parameter int CNT_W   = 16,
  parameter int EN_BZ   = 1
) (
  input  logic             clk_i,
  input  logic             rst_n,
  ctrl_decode_stage_if.slave bus,
  output logic [CNT_W-1:0] stall_cnt_o
);

  typedef struct packed {
    logic               valid;
    logic               illegal;
    ctrl_t              ctrl;
    logic [RADDR_W-1:0] rs;
    logic [RADDR_W-1:0] rt;
    logic [RADDR_W-1:0] dst;
  } idex_t;

  ctrl_t              dec_ctrl;
  logic [RADDR_W-1:0] dec_rs;
  logic [RADDR_W-1:0] dec_rt;
  logic [RADDR_W-1:0] dec_dst;
  logic               dec_illegal;
  logic               uses_rs;
  logic               uses_rt;
  logic               hazard;
  logic               cnt_inc;
  idex_t              dec_word;
  idex_t              ex_d;
  idex_t              ex_q;
  logic [CNT_W-1:0]   cnt_q;

  ctrl_decode_comb #(
    .INSTR_W (INSTR_W),
    .RADDR_W (RADDR_W),
    .EN_BZ   (EN_BZ)
  ) u_decode (
    .instr       (bus.instr_i),
    .instr_valid (bus.instr_valid_i),
    .ctrl        (dec_ctrl),
    .rs          (dec_rs),
    .rt          (dec_rt),
    .dst         (dec_dst),
    .illegal     (dec_illegal),
    .uses_rs     (uses_rs),
    .uses_rt     (uses_rt)
  );

  always_comb begin
    dec_word         = '0;
    dec_word.valid   = 1'b1;
    dec_word.illegal = dec_illegal;
    dec_word.ctrl    = dec_ctrl;
    dec_word.rs      = dec_rs;
    dec_word.rt      = dec_rt;
    dec_word.dst     = dec_dst;
  end

  // A load writing $0 never produces a usable value, so it cannot cause a stall.
  assign hazard = ex_q.valid && ex_q.ctrl.memread && (ex_q.dst != '0) &&
                  ((uses_rs && (dec_rs == ex_q.dst)) || (uses_rt && (dec_rt == ex_q.dst)));

  always_comb begin
    ex_d = '0;
    if (bus.flush_i)            ex_d = '0;
    else if (bus.hold_i)        ex_d = ex_q;
    else if (hazard)            ex_d = '0;
    else if (bus.instr_valid_i) ex_d = dec_word;
  end

  assign bus.stall_o = !bus.flush_i && (bus.hold_i || hazard);
  assign cnt_inc     = !bus.flush_i && !bus.hold_i && hazard;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q <= ex_d;
      if (cnt_inc && (cnt_q != '1)) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.ex_valid_o     = ex_q.valid;
  assign bus.ex_alu_op_o    = ALUOP_W'(ex_q.ctrl.alu_code);
  assign bus.ex_alusrc_o    = ex_q.ctrl.alusrc;
  assign bus.ex_branch_o    = ex_q.ctrl.branch;
  assign bus.ex_branch_eq_o = ex_q.ctrl.branch_eq;
  assign bus.ex_memread_o   = ex_q.ctrl.memread;
  assign bus.ex_memwrite_o  = ex_q.ctrl.memwrite;
  assign bus.ex_regwrite_o  = ex_q.ctrl.regwrite;
  assign bus.ex_wb_sel_o    = ex_q.ctrl.wb_sel;
  assign bus.ex_rs_o        = ex_q.rs;
  assign bus.ex_rt_o        = ex_q.rt;
  assign bus.ex_dst_o       = ex_q.dst;
  assign bus.ex_illegal_o   = ex_q.illegal;
  assign stall_cnt_o        = cnt_q;

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// Scoreboard bench: default stage (A) and a CNT_W=2, EN_BZ=0 stage (B) share one stimulus stream.
module tb_ctrl_decode_stage;

  typedef struct packed {
    logic        valid;
    logic [3:0]  alu;
    logic [1:0]  src;
    logic        br;
    logic        beq;
    logic        mr;
    logic        mw;
    logic        rw;
    logic [1:0]  wb;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dst;
    logic        ill;
    logic [15:0] cnt;
  } exp_t;

  localparam int EXP_W = $bits(exp_t);

  localparam logic [31:0] I_ADDI = 32'h2008_0005;
  localparam logic [31:0] I_LW9  = 32'h8D09_0000;
  localparam logic [31:0] I_ADD  = 32'h012B_5020;
  localparam logic [31:0] I_SW   = 32'hAD09_0004;
  localparam logic [31:0] I_JAL  = 32'h0C00_0010;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] cnt_a;
  logic [1:0]  cnt_b;

  ctrl_decode_stage_if #(.INSTR_W(32), .ALUOP_W(4), .RADDR_W(5)) bus_a ();
  ctrl_decode_stage_if #(.INSTR_W(32), .ALUOP_W(4), .RADDR_W(5)) bus_b ();

  assign bus_b.instr_i       = bus_a.instr_i;
  assign bus_b.instr_valid_i = bus_a.instr_valid_i;
  assign bus_b.flush_i       = bus_a.flush_i;
  assign bus_b.hold_i        = bus_a.hold_i;

  ctrl_decode_stage #(.INSTR_W(32), .ALUOP_W(4), .RADDR_W(5), .CNT_W(16), .EN_BZ(1)) dut_a (
    .clk_i(clk), .rst_n(rst_n), .bus(bus_a), .stall_cnt_o(cnt_a));

  ctrl_decode_stage #(.INSTR_W(32), .ALUOP_W(4), .RADDR_W(5), .CNT_W(2), .EN_BZ(0)) dut_b (
    .clk_i(clk), .rst_n(rst_n), .bus(bus_b), .stall_cnt_o(cnt_b));

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  int n_tests = 0;
  int n_fail  = 0;
  logic [EXP_W-1:0] exp_a_q[$];
  logic [EXP_W-1:0] exp_b_q[$];
  logic [0:0]       stall_q[$];
  logic             mon_en = 1'b0;
  logic             pend   = 1'b0;
  int               mon_n  = 0;
  logic [EXP_W-1:0] ea_m;
  logic [EXP_W-1:0] eb_m;
  logic [0:0]       st_m;

  function automatic exp_t mk(input int v, input int alu, input int src, input int br,
                              input int beq, input int mr, input int mw, input int rw,
                              input int wb, input int rs, input int rt, input int dst,
                              input int ill, input int cnt);
    exp_t e;
    e.valid = 1'(v);   e.alu = 4'(alu); e.src = 2'(src); e.br = 1'(br);
    e.beq   = 1'(beq); e.mr  = 1'(mr);  e.mw  = 1'(mw);  e.rw = 1'(rw);
    e.wb    = 2'(wb);  e.rs  = 5'(rs);  e.rt  = 5'(rt);  e.dst = 5'(dst);
    e.ill   = 1'(ill); e.cnt = 16'(cnt);
    return e;
  endfunction

  function automatic exp_t f_bub(input int c);  return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, c);   endfunction
  function automatic exp_t f_addi(input int c); return mk(1, 1, 1, 0, 0, 0, 0, 1, 0, 0, 8, 8, 0, c);   endfunction
  function automatic exp_t f_lw9(input int c);  return mk(1, 7, 1, 0, 0, 1, 0, 1, 1, 8, 9, 9, 0, c);   endfunction
  function automatic exp_t f_add(input int c);  return mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 9, 11, 10, 0, c); endfunction
  function automatic exp_t f_sw(input int c);   return mk(1, 8, 1, 0, 0, 0, 1, 0, 0, 8, 9, 0, 0, c);   endfunction
  function automatic exp_t f_jal(input int c);  return mk(1, 12, 0, 0, 0, 0, 0, 1, 2, 0, 0, 31, 0, c); endfunction

  function automatic exp_t act_a();
    exp_t e;
    e.valid = bus_a.ex_valid_o;   e.alu = bus_a.ex_alu_op_o;     e.src = bus_a.ex_alusrc_o;
    e.br    = bus_a.ex_branch_o;  e.beq = bus_a.ex_branch_eq_o;  e.mr  = bus_a.ex_memread_o;
    e.mw    = bus_a.ex_memwrite_o; e.rw = bus_a.ex_regwrite_o;   e.wb  = bus_a.ex_wb_sel_o;
    e.rs    = bus_a.ex_rs_o;      e.rt  = bus_a.ex_rt_o;         e.dst = bus_a.ex_dst_o;
    e.ill   = bus_a.ex_illegal_o; e.cnt = cnt_a;
    return e;
  endfunction

  function automatic exp_t act_b();
    exp_t e;
    e.valid = bus_b.ex_valid_o;   e.alu = bus_b.ex_alu_op_o;     e.src = bus_b.ex_alusrc_o;
    e.br    = bus_b.ex_branch_o;  e.beq = bus_b.ex_branch_eq_o;  e.mr  = bus_b.ex_memread_o;
    e.mw    = bus_b.ex_memwrite_o; e.rw = bus_b.ex_regwrite_o;   e.wb  = bus_b.ex_wb_sel_o;
    e.rs    = bus_b.ex_rs_o;      e.rt  = bus_b.ex_rt_o;         e.dst = bus_b.ex_dst_o;
    e.ill   = bus_b.ex_illegal_o; e.cnt = {14'b0, cnt_b};
    return e;
  endfunction

  task automatic check(input string name, input int idx, input logic [EXP_W-1:0] act,
                       input logic [EXP_W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  // driver: present one ID-stage vector for one cycle and record what it must produce
  task automatic step_ab(input logic [31:0] ins, input logic v, input logic f, input logic h,
                         input logic st, input exp_t ea, input exp_t eb);
    bus_a.instr_i       = ins;
    bus_a.instr_valid_i = v;
    bus_a.flush_i       = f;
    bus_a.hold_i        = h;
    stall_q.push_back(st);
    exp_a_q.push_back(ea);
    exp_b_q.push_back(eb);
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic [31:0] ins, input logic v, input logic f, input logic h,
                      input logic st, input exp_t ea, input int cb);
    exp_t eb;
    eb     = ea;
    eb.cnt = 16'(cb);
    step_ab(ins, v, f, h, st, ea, eb);
  endtask

  // monitor: stall is checked in the cycle it is driven, ID/EX one edge later
  always @(negedge clk) begin
    if (mon_en) begin
      if (pend) begin
        if (exp_a_q.size() == 0 || exp_b_q.size() == 0) begin
          check("ex_queue_underflow", mon_n, EXP_W'(1), EXP_W'(0));
        end else begin
          ea_m = exp_a_q.pop_front();
          eb_m = exp_b_q.pop_front();
          check("ex_a", mon_n, act_a(), ea_m);
          check("ex_b", mon_n, act_b(), eb_m);
        end
      end
      if (stall_q.size() > 0) begin
        st_m = stall_q.pop_front();
        mon_n++;
        check("stall_a", mon_n, EXP_W'(bus_a.stall_o), EXP_W'(st_m));
        check("stall_b", mon_n, EXP_W'(bus_b.stall_o), EXP_W'(st_m));
        pend = 1'b1;
      end else begin
        pend = 1'b0;
      end
    end
  end

  initial begin
    int c;
    int nc;
    rst_n               = 1'b0;
    bus_a.instr_i       = '0;
    bus_a.instr_valid_i = 1'b0;
    bus_a.flush_i       = 1'b0;
    bus_a.hold_i        = 1'b0;
    #12;
    check("reset_a", 0, act_a(), '0);
    check("reset_b", 0, act_b(), '0);
    check("reset_stall", 0, EXP_W'({bus_a.stall_o, bus_b.stall_o}), '0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    // ADDI, then load-use with the stalled add re-presented
    step(I_ADDI, 1, 0, 0, 0, f_addi(0), 0);
    step(I_LW9,  1, 0, 0, 0, f_lw9(0), 0);
    step(I_ADD,  1, 0, 0, 1, f_bub(1), 1);
    step(I_ADD,  1, 0, 0, 0, f_add(1), 1);
    // flush beats the hazard; then a load into $0 followed by a $0 reader
    step(I_LW9,  1, 0, 0, 0, f_lw9(1), 1);
    step(I_ADD,  1, 1, 0, 0, f_bub(1), 1);
    step(32'h8D00_0000, 1, 0, 0, 0, mk(1, 7, 1, 0, 0, 1, 0, 1, 1, 8, 0, 0, 0, 1), 1);
    step(32'h0000_5020, 1, 0, 0, 0, mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 10, 0, 1), 1);
    // JAL held for three cycles
    step(I_JAL, 1, 0, 0, 0, f_jal(1), 1);
    for (int i = 0; i < 3; i++) step(I_ADDI, 1, 0, 1, 1, f_jal(1), 1);
    step(I_ADDI, 1, 0, 0, 0, f_addi(1), 1);
    // illegal opcode, BLEZ (legal in A, illegal in B), BEQ, SW, idle
    step(32'hFC00_0000, 1, 0, 0, 0, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1), 1);
    step_ab(32'h1900_0000, 1, 0, 0, 0, mk(1, 9, 2, 0, 0, 0, 0, 0, 0, 8, 0, 0, 0, 1),
            mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 8, 0, 0, 1, 1));
    step(32'h1109_0003, 1, 0, 0, 0, mk(1, 3, 0, 1, 1, 0, 0, 0, 0, 8, 9, 0, 0, 1), 1);
    step(I_SW, 1, 0, 0, 0, f_sw(1), 1);
    step(32'h0, 0, 0, 0, 0, f_bub(1), 1);
    // hold while a load-use pair is pending: no count until hold drops
    step(I_LW9, 1, 0, 0, 0, f_lw9(1), 1);
    step(I_ADD, 1, 0, 1, 1, f_lw9(1), 1);
    step(I_ADD, 1, 0, 0, 1, f_bub(2), 2);
    step(I_ADD, 1, 0, 0, 0, f_add(2), 2);
    // three more hazards: B saturates at 3
    for (int i = 0; i < 3; i++) begin
      c  = 2 + i;
      nc = c + 1;
      step(I_LW9, 1, 0, 0, 0, f_lw9(c), (c > 3) ? 3 : c);
      step((i % 2 == 0) ? I_SW : I_ADD, 1, 0, 0, 1, f_bub(nc), (nc > 3) ? 3 : nc);
      step((i % 2 == 0) ? I_SW : I_ADD, 1, 0, 0, 0,
           (i % 2 == 0) ? f_sw(nc) : f_add(nc), (nc > 3) ? 3 : nc);
    end
    step(32'h0, 0, 0, 0, 0, f_bub(5), 3);

    repeat (3) @(negedge clk);
    #1;
    mon_en = 1'b0;
    pend   = 1'b0;
    check("queues_drained", 0, EXP_W'(exp_a_q.size() + exp_b_q.size() + stall_q.size()), '0);

    // asynchronous reset in the middle of a stall
    bus_a.instr_i       = I_LW9;
    bus_a.instr_valid_i = 1'b1;
    @(posedge clk);
    #1;
    bus_a.instr_i = I_ADD;
    #2;
    check("pre_reset_stall", 0, EXP_W'({bus_a.stall_o, bus_b.stall_o}), EXP_W'(2'b11));
    check("pre_reset_a", 0, act_a(), f_lw9(5));
    check("pre_reset_b", 0, act_b(), f_lw9(3));
    rst_n = 1'b0;
    #1;
    check("midreset_a", 0, act_a(), '0);
    check("midreset_b", 0, act_b(), '0);
    check("midreset_stall", 0, EXP_W'({bus_a.stall_o, bus_b.stall_o}), '0);
    #2;
    rst_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ctrl_decode_stage.md
Name: ctrl_decode_stage

Overview:
Pipelined successor to the combinational main decoder. It decodes opcode `instr_i[31:26]` of the instruction in ID and registers the full control bundle plus register addresses into an ID/EX control register. It detects load-use hazards against the instruction already in EX, then inserts a bubble and stalls IF/ID. It honours downstream hold and branch flush, and counts hazard bubbles.

Parameters:
- INSTR_W, 32, instruction width; opcode is always `[INSTR_W-1:INSTR_W-6]`.
- ALUOP_W, 4, width of `ex_alu_op_o`; must be ≥4.
- RADDR_W, 5, register-address width; link register index = all ones (31 at default).
- CNT_W, 16, width of the saturating stall counter.
- EN_BZ, 1, 1 = BLEZ/BGTZ decoded; 0 = those opcodes treated as illegal.

Ports:
- clk_i, in, 1, clock, rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- instr_i, in, INSTR_W, instruction in ID (from IF/ID register).
- instr_valid_i, in, 1, `instr_i` holds a real instruction.
- flush_i, in, 1, taken branch/jump: squash the ID instruction.
- hold_i, in, 1, EX not accepting: freeze ID/EX.
- stall_o, out, 1, freeze PC and IF/ID this cycle (combinational).
- ex_valid_o, out, 1, ID/EX holds a real instruction.
- ex_alu_op_o, out, ALUOP_W, ALU op code (see Behaviour).
- ex_alusrc_o, out, 2, 0 = reg, 1 = imm, 2 = zero.
- ex_branch_o, out, 1, BEQ/BNE.
- ex_branch_eq_o, out, 1, BEQ.
- ex_memread_o, out, 1, LW.
- ex_memwrite_o, out, 1, SW.
- ex_regwrite_o, out, 1, writes register file.
- ex_wb_sel_o, out, 2, 0 = ALU, 1 = mem, 2 = PC+4.
- ex_rs_o, out, RADDR_W, rs field.
- ex_rt_o, out, RADDR_W, rt field.
- ex_dst_o, out, RADDR_W, resolved destination register.
- ex_illegal_o, out, 1, undecodable opcode reached EX.
- stall_cnt_o, out, CNT_W, saturating count of hazard bubbles.

Behaviour:
- **Reset:** reset is asynchronous, active-low on `rst_n`; one clock `clk_i`. While `rst_n`=0, every registered output is 0 and `stall_o`=0. Reset mid-stall discards the stalled instruction.
- **Opcode map** (opcode → ALU op, alusrc, regwrite, wb_sel, dst):
  - 000000 R_TYPE=0, 0, 1, 0, rd
  - 001000 ADDI=1, 1, 1, 0, rt
  - 001011 SLTIU=2, 1, 1, 0, rt
  - 000100 BEQ=3, 0, 0, –, 0
  - 001111 LUI=4, 1, 1, 0, rt
  - 001101 ORI=5, 1, 1, 0, rt
  - 000101 BNE=6, 0, 0, –, 0
  - 100011 LW=7, 1, 1, 1, rt
  - 101011 SW=8, 1, 0, –, 0
  - 000110 BLEZ=9, 2, 0, –, 0
  - 000111 BGTZ=10, 2, 0, –, 0
  - 000010 J=11, 0, 0, –, 0
  - 000011 JAL=12, 0, 1, 2, all-ones
- ALU op is zero-extended to ALUOP_W. "–" means wb_sel=0.
- **Illegal opcode** (any other, or BLEZ/BGTZ with EN_BZ=0): `ex_illegal_o`=1, `ex_valid_o`=1, `regwrite`/`memread`/`memwrite`/`branch` all 0, ALU op 0.
- **Source use:**
  - uses_rs = valid & not (J, JAL, LUI).
  - uses_rt = valid & (R_TYPE, BEQ, BNE, SW).
- **Hazard** (combinational) = `ex_valid_o` & `ex_memread_o` & `ex_dst_o`≠0 & ((uses_rs & rs==`ex_dst_o`) | (uses_rt & rt==`ex_dst_o`)).
- **Per-cycle priority**, evaluated every posedge:
  1. flush_i: ID/EX ← bubble; `stall_o`=0 (hold ignored; hazard ignored).
  2. hold_i: ID/EX unchanged; `stall_o`=1.
  3. hazard: ID/EX ← bubble; `stall_o`=1; `stall_cnt_o` += 1, saturating at 2^CNT_W−1.
  4. else: ID/EX ← decode(`instr_i`) if `instr_valid_i`, else bubble; `stall_o`=0.
- **Bubble** = all registered outputs 0 (including `ex_valid_o`, `ex_illegal_o`, addresses).
- **Latency:** decode visible on ID/EX outputs exactly 1 cycle after the accepting edge.
- **Stall length:** a load-use hazard produces exactly one bubble. On the next cycle EX holds the bubble, so the hazard clears and the stalled instruction is accepted.
- **Counter:** `stall_cnt_o` changes only on hazard bubbles, never on hold or flush. It clears only on reset.

Decomposition:
- Shared package `ctrl_pkg`:
  - opcode localparams (OP_RTYPE … OP_JAL);
  - ALU op codes 0–12;
  - ALUSRC_REG/IMM/ZERO;
  - WB_ALU/MEM/PC4;
  - control-bundle field widths.
- One natural sub-module: `ctrl_decode_comb` — pure opcode → control bundle, including illegal flag and uses_rs/uses_rt. The top level holds the hazard logic, priority mux, ID/EX register and counter.

Test Plan:
- **Reset/ADDI:** `rst_n`=0 → all outputs 0. Release, then present `instr_i`=0x2008_0005 (addi $8,$0,5) valid → next cycle `ex_alu_op_o`=1, `alusrc`=1, `regwrite`=1, `ex_dst_o`=8, `ex_valid_o`=1.
- **Load-use:** lw $9,0($8) then add $10,$9,$11 → cycle 2: `stall_o`=1, ID/EX = bubble. Cycle 3: add in ID/EX with `ex_dst_o`=10. `stall_cnt_o`=1.
- **Flush beats hazard:** same lw/add pair with `flush_i`=1 on the hazard cycle → `stall_o`=0, bubble, `stall_cnt_o` unchanged. Also `ex_dst_o`=0 LW followed by a $0 user → no stall.
- **Hold:** `hold_i`=1 for 3 cycles while JAL is in ID/EX → outputs stay ALU op 12, `wb_sel`=2, `ex_dst_o`=31; `stall_o`=1 throughout.
- **Illegal/mode:** opcode 0x3F → `ex_illegal_o`=1, `regwrite`=0. EN_BZ=0 with BLEZ → illegal. EN_BZ=1 with BLEZ → ALU op 9, `alusrc`=2.
- **Saturation:** CNT_W=2, five load-use hazards → `stall_cnt_o` 1, 2, 3, 3, 3. Asserting `rst_n`=0 mid-stall → counter and ID/EX immediately 0.
